// File: rtl/simon_if.sv
// Game-side bus of the Simon sequencer: start/random/button inputs and LED/status outputs.
// The master drives the game inputs, the slave (sequencer) drives playback and status.
interface simon_if #(
  parameter int unsigned LEN_W = 2
);
  logic             start;
  logic [31:0]      rand_in;
  logic             btn_valid;
  logic [1:0]       btn_color;
  logic             led_on;
  logic [1:0]       led_color;
  logic             await_input;
  logic [LEN_W:0]   round;
  logic             win;
  logic             lose;

  modport master (
    output start, rand_in, btn_valid, btn_color,
    input  led_on, led_color, await_input, round, win, lose
  );

  modport slave (
    input  start, rand_in, btn_valid, btn_color,
    output led_on, led_color, await_input, round, win, lose
  );
endinterface

// File: rtl/simon_sequencer.sv
// Simon game-round controller: grows a colour sequence from the LFSR, plays it out on the LED
// with fixed on/off timing, then checks player presses against it and reports win/lose.
module simon_sequencer #(
  parameter int unsigned LEN_W         = 2,
  parameter int unsigned ON_TICKS      = 25000000,
  parameter int unsigned OFF_TICKS     = 12500000,
  parameter int unsigned TIMEOUT_TICKS = 250000000
) (
  input  logic    clk,
  input  logic    reset,
  simon_if.slave  bus
);

  localparam int unsigned MaxLen = 2 ** LEN_W;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAdd     = 3'd1;
  localparam logic [2:0] StShowOn  = 3'd2;
  localparam logic [2:0] StShowOff = 3'd3;
  localparam logic [2:0] StWaitIn  = 3'd4;
  localparam logic [2:0] StWin     = 3'd5;
  localparam logic [2:0] StLose    = 3'd6;

  localparam logic [31:0]    OnLast      = 32'(ON_TICKS - 1);
  localparam logic [31:0]    OffLast     = 32'(OFF_TICKS - 1);
  localparam logic [31:0]    TimeoutLast = 32'(TIMEOUT_TICKS - 1);
  localparam logic [LEN_W:0] MaxLenW     = (LEN_W + 1)'(MaxLen);
  localparam logic [LEN_W:0] OneW        = (LEN_W + 1)'(1);

  logic [2:0]       state_q, state_d;
  logic [LEN_W:0]   len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [31:0]      timer_q, timer_d;

  // Sequence storage is deliberately not reset; entries at or beyond len are never read.
  logic [1:0]       seq_q [MaxLen];
  logic             seq_we;

  logic [1:0]       cur_color;
  logic             last_idx;
  logic             timer_on_done;
  logic             timer_off_done;
  logic             timer_to_done;
  logic             unused_rand;

  assign cur_color      = seq_q[idx_q];
  assign last_idx       = ({1'b0, idx_q} == (len_q - OneW));
  assign timer_on_done  = (timer_q == OnLast);
  assign timer_off_done = (timer_q == OffLast);
  assign timer_to_done  = (timer_q == TimeoutLast);
  assign unused_rand    = ^bus.rand_in[31:2];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    seq_we  = 1'b0;

    if (bus.start) begin
      // A new game pre-empts everything, including a press in the same cycle.
      state_d = StAdd;
      len_d   = '0;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
        end

        StAdd: begin
          seq_we  = 1'b1;
          len_d   = len_q + OneW;
          idx_d   = '0;
          timer_d = '0;
          state_d = StShowOn;
        end

        StShowOn: begin
          if (timer_on_done) begin
            timer_d = '0;
            state_d = StShowOff;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end

        StShowOff: begin
          if (timer_off_done) begin
            timer_d = '0;
            if (last_idx) begin
              idx_d   = '0;
              state_d = StWaitIn;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = StShowOn;
            end
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end

        StWaitIn: begin
          // A press on the final timeout cycle is honoured instead of the timeout.
          if (bus.btn_valid) begin
            timer_d = '0;
            if (bus.btn_color != cur_color) begin
              state_d = StLose;
            end else if (!last_idx) begin
              idx_d = idx_q + 1'b1;
            end else if (len_q == MaxLenW) begin
              state_d = StWin;
            end else begin
              state_d = StAdd;
            end
          end else if (timer_to_done) begin
            timer_d = '0;
            state_d = StLose;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end

        StWin, StLose: begin
        end

        default: begin
          state_d = StIdle;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  // ADD is only reachable with len < MaxLen, so the low bits address a free slot.
  always_ff @(posedge clk) begin
    if (seq_we) begin
      seq_q[len_q[LEN_W-1:0]] <= bus.rand_in[1:0];
    end
  end

  // Status outputs decode straight from state so reset clears them asynchronously.
  assign bus.led_on      = (state_q == StShowOn);
  assign bus.led_color   = (state_q == StShowOn) ? cur_color : 2'b00;
  assign bus.await_input = (state_q == StWaitIn);
  assign bus.round       = len_q;
  assign bus.win         = (state_q == StWin);
  assign bus.lose        = (state_q == StLose);

  ap_len_bound: assert property (@(posedge clk) disable iff (reset) len_q <= MaxLenW);
  ap_flags_excl: assert property (@(posedge clk) disable iff (reset) !(bus.win && bus.lose));

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer: a scoreboard of expected LED playback colours is
// filled when each round is set up and drained by a monitor watching the LED.
module tb_simon_sequencer;

  localparam int unsigned LEN_W = 2;
  localparam int unsigned ON_T  = 4;
  localparam int unsigned OFF_T = 2;
  localparam int unsigned TO_T  = 20;

  logic clk;
  logic reset;

  simon_if #(.LEN_W(LEN_W)) bus ();

  simon_sequencer #(
    .LEN_W         (LEN_W),
    .ON_TICKS      (ON_T),
    .OFF_TICKS     (OFF_T),
    .TIMEOUT_TICKS (TO_T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] exp_led_q [$];
  logic [1:0] model_seq [4];
  int         model_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] c);
    bus.btn_valid = 1'b1;
    bus.btn_color = c;
    tick();
    bus.btn_valid = 1'b0;
  endtask

  // Called one sample after ADD is entered; returns in the first WAIT_IN cycle.
  task automatic playback(input int len);
    int n;
    for (int i = 0; i < len; i++) exp_led_q.push_back(model_seq[i]);
    chk("add_led_off", 32'(bus.led_on), 32'd0);
    tick();
    n = 1;
    chk("show_latency", 32'(bus.led_on), 32'd1);
    while (!bus.await_input && n < 200) begin
      tick();
      n++;
    end
    chk("play_cycles", n, 32'(len * (ON_T + OFF_T) + 1));
    chk("round", 32'(bus.round), 32'(len));
  endtask

  task automatic start_game(input logic [1:0] c);
    bus.rand_in  = {30'h0, c};
    model_seq[0] = c;
    model_len    = 1;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    chk("start_clr_lose", 32'(bus.lose), 32'd0);
    chk("start_clr_win", 32'(bus.win), 32'd0);
    playback(1);
  endtask

  // Answer the current sequence correctly, adding colour c as the next entry.
  task automatic grow(input logic [1:0] c);
    logic [31:0] r;
    r               = $urandom();
    r[1:0]          = c;
    bus.rand_in     = r;
    model_seq[model_len] = c;
    for (int i = 0; i < model_len; i++) press(model_seq[i]);
    model_len++;
    playback(model_len);
  endtask

  // LED monitor: each lit segment must match the next scoreboard colour and last ON_T cycles.
  int         on_cnt = 0;
  logic [1:0] seg_color = 2'b00;
  logic       prev_led = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      on_cnt   = 0;
      prev_led = 1'b0;
    end else begin
      if (bus.led_on) begin
        if (on_cnt == 0) seg_color = bus.led_color;
        else chk("led_color_stable", 32'(bus.led_color), 32'(seg_color));
        on_cnt++;
      end else if (prev_led) begin
        chk("led_dark_color", 32'(bus.led_color), 32'd0);
        if (exp_led_q.size() == 0) begin
          chk("led_unexpected", 32'd1, 32'd0);
        end else begin
          chk("led_color", 32'(seg_color), 32'(exp_led_q.pop_front()));
          chk("led_on_len", on_cnt, 32'(ON_T));
        end
        on_cnt = 0;
      end
      prev_led = bus.led_on;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.rand_in   = '0;
    bus.btn_valid = 1'b0;
    bus.btn_color = '0;
    model_len     = 0;
    repeat (3) tick();
    chk("rst_led_on", 32'(bus.led_on), 32'd0);
    chk("rst_led_color", 32'(bus.led_color), 32'd0);
    chk("rst_await", 32'(bus.await_input), 32'd0);
    chk("rst_round", 32'(bus.round), 32'd0);
    chk("rst_win", 32'(bus.win), 32'd0);
    chk("rst_lose", 32'(bus.lose), 32'd0);
    reset = 1'b0;
    press(2'd1);
    repeat (5) tick();
    chk("idle_await", 32'(bus.await_input), 32'd0);
    chk("idle_led", 32'(bus.led_on), 32'd0);
    chk("idle_round", 32'(bus.round), 32'd0);

    // Rounds 1 and 2: sequence 3, 1
    start_game(2'd3);
    grow(2'd1);

    // Wrong second colour loses; later presses ignored; start clears
    press(2'd3);
    chk("mid_seq_await", 32'(bus.await_input), 32'd1);
    press(2'd2);
    chk("wrong_lose", 32'(bus.lose), 32'd1);
    chk("wrong_await", 32'(bus.await_input), 32'd0);
    press(2'd1);
    press(2'd3);
    chk("lose_sticky", 32'(bus.lose), 32'd1);
    chk("lose_round_hold", 32'(bus.round), 32'd2);
    start_game(2'd2);

    // Timeout: 20 idle cycles in WAIT_IN
    repeat (TO_T - 1) tick();
    chk("pre_timeout_lose", 32'(bus.lose), 32'd0);
    chk("pre_timeout_await", 32'(bus.await_input), 32'd1);
    tick();
    chk("timeout_lose", 32'(bus.lose), 32'd1);
    chk("timeout_await", 32'(bus.await_input), 32'd0);

    // Press on the last timeout cycle is accepted, then play through to a win
    start_game(2'd0);
    repeat (TO_T - 1) tick();
    grow(2'd1);
    grow(2'd2);
    grow(2'd3);
    for (int i = 0; i < model_len; i++) press(model_seq[i]);
    chk("win", 32'(bus.win), 32'd1);
    chk("win_round", 32'(bus.round), 32'd4);
    chk("win_await", 32'(bus.await_input), 32'd0);
    chk("win_lose", 32'(bus.lose), 32'd0);
    press(2'd1);
    chk("win_sticky", 32'(bus.win), 32'd1);

    // Reset during SHOW_ON drops the LED without waiting for a clock
    bus.rand_in = 32'h1;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    tick();
    chk("pre_reset_led", 32'(bus.led_on), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("async_reset_led", 32'(bus.led_on), 32'd0);
    chk("async_reset_round", 32'(bus.round), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // start and a wrong press together: start wins
    start_game(2'd2);
    bus.rand_in   = 32'h3;
    model_seq[0]  = 2'd3;
    model_len     = 1;
    bus.start     = 1'b1;
    bus.btn_valid = 1'b1;
    bus.btn_color = 2'd0;
    tick();
    bus.start     = 1'b0;
    bus.btn_valid = 1'b0;
    chk("start_beats_btn", 32'(bus.lose), 32'd0);
    playback(1);

    repeat (10) tick();
    chk("scoreboard_empty", 32'(exp_led_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
